// File: rtl/softmax_out_writer_pkg.sv
// Shared widths and FSM encoding for the softmax output writer.
package softmax_out_writer_pkg;

    localparam int SMW_DATAWIDTH  = 32;
    localparam int SMW_ADDRSIZE   = 10;
    localparam int SMW_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } smw_state_t;

endpackage

// File: rtl/softmax_out_writer_fifo.sv
// First-word-fall-through FIFO with flush; the head is valid whenever empty is low.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/softmax_out_writer.sv
// Writes the softmax result stream to output memory at consecutive addresses,
// buffering write-port stalls and flagging end-of-vector and lost data.
//
// state | meaning
// IDLE  | not armed, input ignored
// RUN   | armed, accepting results and writing them out
// DONE  | last expected word written; vec_done high for this cycle
module softmax_out_writer
    import softmax_out_writer_pkg::*;
#(
    parameter int DATAWIDTH  = SMW_DATAWIDTH,
    parameter int ADDRSIZE   = SMW_ADDRSIZE,
    parameter int FIFO_DEPTH = SMW_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [ADDRSIZE-1:0]  out_start_addr,
    input  logic [ADDRSIZE:0]    elem_count,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 wr_en,
    output logic [ADDRSIZE-1:0]  wr_addr,
    output logic [DATAWIDTH-1:0] wr_data,
    input  logic                 wr_ready,
    output logic                 busy,
    output logic                 vec_done,
    output logic                 overflow
);

    smw_state_t          state;
    logic [ADDRSIZE:0]   count_lat;
    logic [ADDRSIZE:0]   wr_cnt;
    logic                running;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATAWIDTH-1:0] fifo_head;
    logic                wr_fire;
    logic                fifo_push;
    logic                drop;

    assign running   = (state == RUN);
    assign wr_en     = running && !fifo_empty;
    assign wr_data   = fifo_head;
    assign wr_fire   = wr_en && wr_ready;
    assign fifo_push = running && in_valid && !init;
    assign drop      = fifo_push && fifo_full && !wr_fire;

    sync_fifo_fwft #(
        .WIDTH (DATAWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (init),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (wr_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            vec_done  <= 1'b0;
            overflow  <= 1'b0;
            count_lat <= '0;
            wr_cnt    <= '0;
            wr_addr   <= '0;
        end else begin
            vec_done <= 1'b0;
            if (init) begin
                // Re-arm from any state; a write completing this cycle is not counted.
                count_lat <= elem_count;
                wr_cnt    <= '0;
                wr_addr   <= out_start_addr;
                overflow  <= 1'b0;
                if (elem_count == '0) begin
                    state    <= DONE;
                    busy     <= 1'b0;
                    vec_done <= 1'b1;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN: begin
                        if (wr_fire) begin
                            wr_cnt  <= wr_cnt + (ADDRSIZE+1)'(1);
                            wr_addr <= wr_addr + ADDRSIZE'(1);
                            if ((wr_cnt + (ADDRSIZE+1)'(1)) == count_lat) begin
                                state    <= DONE;
                                busy     <= 1'b0;
                                vec_done <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_softmax_out_writer.sv
// Scoreboard bench for softmax_out_writer against a queue-based reference model.
module tb_softmax_out_writer;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [AW-1:0] out_start_addr;
    logic [AW:0]   elem_count;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          busy;
    logic          vec_done;
    logic          overflow;

    softmax_out_writer #(.DATAWIDTH(DW), .ADDRSIZE(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .out_start_addr (out_start_addr),
        .elem_count     (elem_count),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .busy           (busy),
        .vec_done       (vec_done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
        logic          done;
        logic          ovf;
    } stat_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    stat_t stat_q[$];
    wr_t   wr_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: vector bookkeeping plus a bounded queue of pending words.
    bit            m_run;
    bit            m_done;
    bit            m_ovf;
    logic [AW-1:0] m_base;
    int            m_count;
    int            m_written;
    logic [DW-1:0] mq[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        m_run = 0; m_done = 0; m_ovf = 0; m_base = '0;
        m_count = 0; m_written = 0; mq.delete();
    endfunction

    function automatic void model_step(bit i_init, logic [AW-1:0] a, logic [AW:0] c,
                                       bit v, logic [DW-1:0] d, bit r);
        bit fire;
        bit ok;
        fire = m_run && (mq.size() > 0) && r;
        if (i_init) begin
            mq.delete();
            m_written = 0; m_base = a; m_count = int'(c); m_ovf = 0;
            m_run  = (c != 0);
            m_done = (c == 0);
        end else begin
            m_done = 0;
            if (m_run) begin
                ok = v && ((mq.size() < DEPTH) || fire);
                if (v && !ok) m_ovf = 1;
                if (fire) begin
                    void'(mq.pop_front());
                    m_written++;
                    if (m_written == m_count) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
                if (ok) mq.push_back(d);
            end
        end
    endfunction

    task automatic cyc(bit i_init, logic [AW-1:0] a, logic [AW:0] c,
                       bit v, logic [DW-1:0] d, bit r);
        stat_t st;
        init = i_init; out_start_addr = a; elem_count = c;
        in_valid = v; in_data = d; wr_ready = r;
        st.en   = m_run && (mq.size() > 0);
        st.addr = st.en ? AW'(m_base + AW'(m_written)) : '0;
        st.data = st.en ? mq[0] : '0;
        st.busy = m_run;
        st.done = m_done;
        st.ovf  = m_ovf;
        stat_q.push_back(st);
        if (st.en && r) wr_q.push_back('{addr: st.addr, data: st.data});
        @(posedge clk);
        #1;
        model_step(i_init, a, c, v, d, r);
    endtask

    task automatic idle(int n, bit r);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, $urandom, r);
    endtask

    task automatic push_words(int n, bit r);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 1, $urandom, r);
    endtask

    // Monitor: compare per-cycle status and every completed write against the scoreboard.
    initial begin
        stat_t st;
        stat_t act;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && stat_q.size() > 0) begin
                st = stat_q.pop_front();
                act.en   = wr_en;
                act.addr = wr_en ? wr_addr : '0;
                act.data = wr_en ? wr_data : '0;
                act.busy = busy;
                act.done = vec_done;
                act.ovf  = overflow;
                chk("status", 64'(act), 64'(st));
                if (wr_en && wr_ready) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", {22'd0, wr_addr, wr_data}, '0);
                    end else begin
                        w = wr_q.pop_front();
                        chk("write_addr", 64'(wr_addr), 64'(w.addr));
                        chk("write_data", 64'(wr_data), 64'(w.data));
                    end
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] b;
        logic [AW:0]   c;
        reset = 1'b0; init = 0; out_start_addr = '0; elem_count = '0;
        in_data = '0; in_valid = 0; wr_ready = 0;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_wr_en", 64'(wr_en), 0);
        chk("reset_wr_addr", 64'(wr_addr), 0);
        chk("reset_wr_data", 64'(wr_data), 0);
        chk("reset_flags", 64'({busy, vec_done, overflow}), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // basic stream
        cyc(1, 10'h010, 11'd4, 0, '0, 1);
        cyc(0, '0, '0, 1, 32'hAAAA_0001, 1);
        cyc(0, '0, '0, 1, 32'hBBBB_0002, 1);
        cyc(0, '0, '0, 1, 32'hCCCC_0003, 1);
        cyc(0, '0, '0, 1, 32'hDDDD_0004, 1);
        idle(4, 1);

        // back-pressure
        cyc(1, 10'h120, 11'd6, 0, '0, 0);
        push_words(6, 0);
        idle(4, 0);
        idle(9, 1);

        // overflow, left running until next init
        cyc(1, 10'h200, 11'd12, 0, '0, 0);
        push_words(10, 0);
        idle(12, 1);

        // address wrap
        cyc(1, 10'h3FE, 11'd4, 0, '0, 1);
        push_words(4, 1);
        idle(4, 1);

        // zero count, then re-init mid vector
        cyc(1, 10'h055, 11'd0, 0, '0, 1);
        idle(3, 1);
        cyc(1, 10'h080, 11'd5, 0, '0, 1);
        push_words(2, 1);
        cyc(0, '0, '0, 1, $urandom, 0);
        cyc(0, '0, '0, 1, $urandom, 0);
        cyc(1, 10'h100, 11'd2, 1, $urandom, 1);
        push_words(2, 1);
        idle(4, 1);

        // randomized vectors
        for (int vct = 0; vct < 8; vct++) begin
            b = AW'($urandom_range(0, 1023));
            c = (AW+1)'($urandom_range(0, 20));
            cyc(1, b, c, 0, '0, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 50; k++)
                cyc(0, '0, '0, ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 3) != 0));
            idle(20, 1);
        end

        // async reset with buffered words
        cyc(1, 10'h050, 11'd8, 0, '0, 0);
        push_words(3, 0);
        #6;
        reset = 1'b0;
        #1;
        chk("async_reset_wr_en", 64'(wr_en), 0);
        chk("async_reset_flags", 64'({busy, overflow}), 0);
        chk("pending_before_reset", 64'(wr_q.size()), 0);
        model_clear();
        stat_q.delete();
        wr_q.delete();
        init = 0; in_valid = 0; wr_ready = 1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        idle(6, 1);
        cyc(1, 10'h3A0, 11'd3, 0, '0, 1);
        push_words(3, 1);
        idle(4, 1);

        #5;
        chk("scoreboard_drained", 64'(wr_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
